// File: rtl/picoctrl_sequencer.sv
// picoctrl_sequencer: two-phase fetch/execute core for the 32-word PicoCtrl instruction ROM.
// Build option PICOCTRL_CSYNC_EN inserts a 2-flop synchroniser on c_in ahead of the condition test.
//
// state | meaning
// ------+---------------------------------------------------------
// FETCH | pc drives rom_addr, instruction register loads rom_data
// EXEC  | condition tested, action performed, pc updated
// HALT  | parked after a halt instruction; only reset leaves here
module picoctrl_sequencer #(
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [1:0]        c_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [IMM_W-1:0]  out_reg0,
    output logic [IMM_W-1:0]  out_reg1,
    output logic [IMM_W-1:0]  out_reg2,
    output logic [IMM_W-1:0]  out_reg3,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [2:0] ACT_WRITE = 3'b001;
    localparam logic [2:0] ACT_JUMP  = 3'b010;
    localparam logic [2:0] ACT_HALT  = 3'b011;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic [15:0]         ir, ir_nxt;
    logic                halt_nxt;
    logic                wr_en;
    logic                cond_ok;
    logic [1:0]          c_eff;
    logic [IMM_W-1:0]    out_q [4];

    logic [2:0]          ir_cond;
    logic [2:0]          ir_act;
    logic [1:0]          ir_reg;
    logic [IMM_W-1:0]    ir_imm;
    logic [ADDR_W-1:0]   ir_target;

    assign ir_cond   = ir[15:13];
    assign ir_act    = ir[12:10];
    assign ir_reg    = ir[9:8];
    assign ir_imm    = ir[IMM_W-1:0];
    assign ir_target = ir[ADDR_W-1:0];

`ifdef PICOCTRL_CSYNC_EN
    logic [1:0] c_s1, c_s2;

    // Synchroniser runs freely, independent of run, so it stays current while frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_s1 <= 2'b00;
            c_s2 <= 2'b00;
        end else begin
            c_s1 <= c_in;
            c_s2 <= c_s1;
        end
    end

    assign c_eff = c_s2;
`else
    assign c_eff = c_in;
`endif

    always_comb begin
        cond_ok = 1'b0;
        case (ir_cond)
            3'b000:  cond_ok = 1'b1;
            3'b001:  cond_ok = ~c_eff[0];
            3'b010:  cond_ok = c_eff[0];
            3'b011:  cond_ok = ~c_eff[1];
            3'b100:  cond_ok = c_eff[1];
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        halt_nxt  = halted;
        wr_en     = 1'b0;
        if (run) begin
            case (state)
                ST_FETCH: begin
                    ir_nxt    = rom_data;
                    state_nxt = ST_EXEC;
                end
                ST_EXEC: begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = pc + 1'b1;
                    if (cond_ok) begin
                        case (ir_act)
                            ACT_WRITE: wr_en = 1'b1;
                            ACT_JUMP:  pc_nxt = ir_target;
                            ACT_HALT: begin
                                pc_nxt    = pc;
                                halt_nxt  = 1'b1;
                                state_nxt = ST_HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_HALT: ;
                default: state_nxt = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_FETCH;
            pc     <= '0;
            ir     <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ir     <= ir_nxt;
            halted <= halt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) out_q[i] <= '0;
        end else if (wr_en) begin
            out_q[ir_reg] <= ir_imm;
        end
    end

    assign rom_addr = pc;
    assign out_reg0 = out_q[0];
    assign out_reg1 = out_q[1];
    assign out_reg2 = out_q[2];
    assign out_reg3 = out_q[3];

endmodule

// File: tb/tb_picoctrl_sequencer.sv
// Bench for picoctrl_sequencer: directed scenarios plus random programs,
// checked every cycle against an instruction-level reference model.
module tb_picoctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [1:0]  c_in;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  out_reg0, out_reg1, out_reg2, out_reg3;
    logic        halted;

    logic [15:0] rom [32];
    assign rom_data = rom[rom_addr];

    picoctrl_sequencer #(.ADDR_W(5), .IMM_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .c_in     (c_in),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_reg0 (out_reg0),
        .out_reg1 (out_reg1),
        .out_reg2 (out_reg2),
        .out_reg3 (out_reg3),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one instruction takes a load phase then an execute phase.
    int          m_pc;
    bit          m_in_exec;
    bit          m_halt;
    int          m_regs [4];
    logic [15:0] m_ir;
    logic [1:0]  m_s1, m_s2;

    function automatic bit cond_true(input int cnd, input logic [1:0] c);
        case (cnd)
            0: return 1'b1;
            1: return c[0] == 1'b0;
            2: return c[0] == 1'b1;
            3: return c[1] == 1'b0;
            4: return c[1] == 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_edge(input bit rst, input bit rn, input logic [1:0] c);
        logic [1:0] cv;
        int cnd, act;
`ifdef PICOCTRL_CSYNC_EN
        cv = m_s2;
`else
        cv = c;
`endif
        if (rst) begin
            m_pc = 0; m_in_exec = 0; m_halt = 0; m_ir = '0;
            m_s1 = '0; m_s2 = '0;
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = c;
        if (!rn || m_halt) return;
        if (!m_in_exec) begin
            m_ir = rom[m_pc];
            m_in_exec = 1;
            return;
        end
        m_in_exec = 0;
        cnd = int'(m_ir[15:13]);
        act = int'(m_ir[12:10]);
        if (cond_true(cnd, cv) && act == 1) begin
            m_regs[m_ir[9:8]] = int'(m_ir[7:0]);
            m_pc = (m_pc + 1) % 32;
        end else if (cond_true(cnd, cv) && act == 2) begin
            m_pc = int'(m_ir[7:0]) % 32;
        end else if (cond_true(cnd, cv) && act == 3) begin
            m_halt = 1;
        end else begin
            m_pc = (m_pc + 1) % 32;
        end
    endfunction

    task automatic tick(input bit rst, input bit rn, input logic [1:0] c);
        @(negedge clk);
        reset = rst;
        run   = rn;
        c_in  = c;
        @(posedge clk);
        model_edge(rst, rn, c);
        #1;
        chk("rom_addr", rom_addr, m_pc);
        chk("out_reg0", out_reg0, m_regs[0]);
        chk("out_reg1", out_reg1, m_regs[1]);
        chk("out_reg2", out_reg2, m_regs[2]);
        chk("out_reg3", out_reg3, m_regs[3]);
        chk("halted",   halted,   m_halt);
    endtask

    initial begin
        int k;
        int lim;
        reset = 1'b1;
        run   = 1'b1;
        c_in  = 2'b00;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = 16'h05A5;                 // always, write reg1, 0xA5
        rom[3] = 16'h8803;                 // c1==1, jump to self
        rom[4] = 16'hE6FF;                 // never, write reg2, 0xFF

        // 1: reset state
        tick(1, 1, 2'b00);
        tick(1, 1, 2'b00);
        chk("t1_addr", rom_addr, 0);
        chk("t1_out0", out_reg0, 0);
        chk("t1_out1", out_reg1, 0);
        chk("t1_halt", halted, 0);

        // 2: first write lands after fetch + exec
        tick(0, 1, 2'b10);
        chk("t2_mid_out1", out_reg1, 0);
        tick(0, 1, 2'b10);
        chk("t2_out1", out_reg1, 8'hA5);
        chk("t2_addr", rom_addr, 1);
        chk("t2_out3", out_reg3, 0);

        // 3: wait loop on c1, then release
        for (int i = 0; i < 14; i++) tick(0, 1, 2'b10);
        chk("t3_loop_addr", rom_addr, 3);
`ifdef PICOCTRL_CSYNC_EN
        lim = 4;
`else
        lim = 2;
`endif
        k = 0;
        while (rom_addr != 5'd4 && k < 8) begin
            tick(0, 1, 2'b00);
            k++;
        end
        chk("t3_exit_addr", rom_addr, 4);
        chk("t3_exit_within_bound", (k <= lim), 1);

        // 4: never-condition write, then wrap 31 -> 0
        tick(0, 1, 2'b11);
        tick(0, 1, 2'b11);
        chk("t4_never_out2", out_reg2, 0);
        chk("t4_addr5", rom_addr, 5);
        for (int i = 0; i < 54; i++) tick(0, 1, 2'(i));
        chk("t4_wrap", rom_addr, 0);

        // 5: halt holds, reset releases
        rom[3] = 16'h0000;
        rom[5] = 16'h0C00;
        tick(1, 1, 2'b00);
        for (int i = 0; i < 12; i++) tick(0, 1, 2'b00);
        chk("t5_halted", halted, 1);
        for (int i = 0; i < 20; i++) tick(0, 1, 2'($urandom_range(0, 3)));
        chk("t5_hold_addr", rom_addr, 5);
        chk("t5_hold_halt", halted, 1);
        tick(1, 1, 2'b00);
        chk("t5_rst_halt", halted, 0);
        chk("t5_rst_addr", rom_addr, 0);

        // 6: freeze in EXEC of a write
        rom[0] = 16'h073C;                 // always, write reg3, 0x3C
        tick(1, 1, 2'b00);
        tick(0, 1, 2'b00);
        for (int i = 0; i < 5; i++) tick(0, 0, 2'b00);
        chk("t6_frozen_out3", out_reg3, 0);
        chk("t6_frozen_addr", rom_addr, 0);
        tick(0, 1, 2'b00);
        chk("t6_out3", out_reg3, 8'h3C);
        chk("t6_addr1", rom_addr, 1);
        tick(0, 1, 2'b00);
        tick(0, 1, 2'b00);
        chk("t6_addr2", rom_addr, 2);

        // 7: random programs with random run / c_in / occasional reset
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 32; i++) rom[i] = 16'($urandom_range(0, 65535));
            tick(1, 1, 2'b00);
            for (int i = 0; i < 400; i++)
                tick(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 80),
                     2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
